spu_rf_writeback: RTL

- Owns the SPU 128x128 register file storage and its two write ports (even pipe, odd pipe).
- Registers pipe results for one write-back stage, then commits them to the array.
- Supplies six read ports (e1,e2,e3,o1,o2,o3) to the register-fetch stage, with write-through bypass from the write-back stage.
- Keeps a per-register busy scoreboard, set at issue and cleared at write-back. Register fetch uses it to raise a stall.

---
 rtl/spu_rf_writeback.sv | 130 +++++++++++++
 1 files changed

// File: rtl/spu_rf_writeback.sv
// SPU register file: 128x128 storage, even/odd write-back stage with bypass,
// six read ports and a per-register busy scoreboard for register-fetch stalls.
module spu_rf_writeback #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned NREG   = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  even_wr_en,
  input  logic [ADDR_W-1:0]     even_wr_addr,
  input  logic [DATA_W-1:0]     even_wr_data,
  input  logic                  odd_wr_en,
  input  logic [ADDR_W-1:0]     odd_wr_addr,
  input  logic [DATA_W-1:0]     odd_wr_data,
  input  logic                  issue_e_valid,
  input  logic [ADDR_W-1:0]     issue_e_dest,
  input  logic                  issue_o_valid,
  input  logic [ADDR_W-1:0]     issue_o_dest,
  input  logic [5:0]            rd_en,
  input  logic [6*ADDR_W-1:0]   rd_addr,
  output logic [6*DATA_W-1:0]   rd_data,
  output logic [5:0]            rd_busy,
  output logic                  stall,
  output logic                  wb_conflict,
  output logic [CNT_W-1:0]      wb_count
);

  localparam int unsigned NPORT = 6;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;

  logic              wb_e_en, wb_o_en;
  logic [ADDR_W-1:0] wb_e_addr, wb_o_addr;
  logic [DATA_W-1:0] wb_e_data, wb_o_data;

  logic              wb_same;
  logic              wb_e_commit;
  logic [1:0]        n_commit;
  logic [CNT_W:0]    cnt_sum;
  logic [NREG-1:0]   set_mask, clr_mask;
  logic [ADDR_W-1:0] port_addr [NPORT];

  // Write-back stage; addr/data only load when the pipe result is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_e_en   <= 1'b0;
      wb_e_addr <= '0;
      wb_e_data <= '0;
      wb_o_en   <= 1'b0;
      wb_o_addr <= '0;
      wb_o_data <= '0;
    end else begin
      wb_e_en <= even_wr_en;
      wb_o_en <= odd_wr_en;
      if (even_wr_en) begin
        wb_e_addr <= even_wr_addr;
        wb_e_data <= even_wr_data;
      end
      if (odd_wr_en) begin
        wb_o_addr <= odd_wr_addr;
        wb_o_data <= odd_wr_data;
      end
    end
  end

  // Odd pipe wins a same-address pair, so the even write is dropped
  assign wb_same     = wb_e_en & wb_o_en & (wb_e_addr == wb_o_addr);
  assign wb_e_commit = wb_e_en & ~wb_same;
  assign n_commit    = {1'b0, wb_e_commit} + {1'b0, wb_o_en};
  assign cnt_sum     = {1'b0, wb_count} + (CNT_W+1)'(n_commit);

  // Register array commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_e_commit) regs[wb_e_addr] <= wb_e_data;
      if (wb_o_en)     regs[wb_o_addr] <= wb_o_data;
    end
  end

  // Scoreboard masks; set is applied after clear so a re-issue stays busy
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_e_valid) set_mask[issue_e_dest] = 1'b1;
    if (issue_o_valid) set_mask[issue_o_dest] = 1'b1;
    if (wb_e_commit)   clr_mask[wb_e_addr]    = 1'b1;
    if (wb_o_en)       clr_mask[wb_o_addr]    = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      wb_conflict <= 1'b0;
      wb_count    <= '0;
    end else begin
      busy        <= (busy & ~clr_mask) | set_mask;
      wb_conflict <= even_wr_en & odd_wr_en & (even_wr_addr == odd_wr_addr);
      wb_count    <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < NPORT; i++) port_addr[i] = rd_addr[i*ADDR_W +: ADDR_W];
  end

  // Read ports with write-through bypass; a committing write is not busy
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (wb_o_en && (wb_o_addr == port_addr[i])) begin
        rd_data[i*DATA_W +: DATA_W] = wb_o_data;
      end else if (wb_e_en && (wb_e_addr == port_addr[i])) begin
        rd_data[i*DATA_W +: DATA_W] = wb_e_data;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = regs[port_addr[i]];
      end
      rd_busy[i] = busy[port_addr[i]]
                 & ~(wb_o_en & (wb_o_addr == port_addr[i]))
                 & ~(wb_e_en & (wb_e_addr == port_addr[i]));
    end
    stall = |(rd_en & rd_busy);
  end

endmodule
